// File: rtl/ham_pkg.sv
// Shared definitions for the Hamming(7,4) receive path.
// Codeword bit i holds code position i+1; parity sits at positions 1, 2 and 4.
package ham_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Parity positions (1-based code positions)
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_P4 = 4;

    // Data positions (1-based code positions)
    localparam int POS_D3 = 3;
    localparam int POS_D5 = 5;
    localparam int POS_D6 = 6;
    localparam int POS_D7 = 7;

    typedef logic [CW_W-1:0]   codeword_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syndrome_t;

endpackage

// File: rtl/ham_syndrome.sv
// Combinational even-parity syndrome for a Hamming(7,4) codeword.
// The result is the binary 1-based position of a single flipped bit, or 0 when clean.
module ham_syndrome
    import ham_pkg::*;
(
    input  codeword_t cw_i,
    output syndrome_t syn_o
);

    // Each syndrome bit checks the positions whose index has that bit set
    always_comb begin
        syn_o    = '0;
        syn_o[0] = cw_i[POS_P1-1] ^ cw_i[POS_D3-1] ^ cw_i[POS_D5-1] ^ cw_i[POS_D7-1];
        syn_o[1] = cw_i[POS_P2-1] ^ cw_i[POS_D3-1] ^ cw_i[POS_D6-1] ^ cw_i[POS_D7-1];
        syn_o[2] = cw_i[POS_P4-1] ^ cw_i[POS_D5-1] ^ cw_i[POS_D6-1] ^ cw_i[POS_D7-1];
    end

endmodule

// File: rtl/hamming_decoder.sv
// Registered Hamming(7,4) single-error-correcting decoder, one-cycle latency.
// Optional feature: define HAM_ERR_COUNT_EN to add a saturating corrected-error
// counter on the err_cnt port.
module hamming_decoder
    import ham_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CW_W-1:0]   e,
    output logic              out_valid,
    output logic [3:0]        p,
    output logic [DATA_W-1:0] c,
    output logic [CW_W-1:0]   cw
`ifdef HAM_ERR_COUNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    syndrome_t syn;
    codeword_t flip_mask;
    codeword_t cw_fix;
    data_t     data_fix;

    logic      out_valid_q, out_valid_d;
    logic [3:0] p_q, p_d;
    data_t     c_q, c_d;
    codeword_t cw_q, cw_d;

    ham_syndrome u_syndrome (
        .cw_i  (e),
        .syn_o (syn)
    );

    // One-hot mask: bit gi is flipped when the syndrome points at position gi+1
    for (genvar gi = 0; gi < CW_W; gi++) begin : g_mask
        assign flip_mask[gi] = (syn == SYN_W'(gi + 1));
    end

    assign cw_fix   = e ^ flip_mask;
    // Data comes from the corrected word so parity-bit hits leave data alone
    assign data_fix = {cw_fix[POS_D7-1], cw_fix[POS_D6-1], cw_fix[POS_D5-1], cw_fix[POS_D3-1]};

    // Next-state for the output registers: load on valid input, otherwise hold
    always_comb begin
        out_valid_d = in_valid;
        p_d         = p_q;
        c_d         = c_q;
        cw_d        = cw_q;
        if (in_valid) begin
            p_d  = {|syn, syn};
            c_d  = data_fix;
            cw_d = cw_fix;
        end
    end

    // Output registers with synchronous reset that wins over in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            c_q         <= '0;
            cw_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            c_q         <= c_d;
            cw_q        <= cw_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign c         = c_q;
    assign cw        = cw_q;

`ifdef HAM_ERR_COUNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count accepted words with a non-zero syndrome, sticking at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (in_valid && (syn != '0) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder with a queue-based scoreboard.
// Build with HAM_ERR_COUNT_EN defined to also exercise the error counter.
module tb_hamming_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] e = '0;
    logic       out_valid;
    logic [3:0] p;
    logic [3:0] c;
    logic [6:0] cw;
`ifdef HAM_ERR_COUNT_EN
    logic [15:0] err_cnt;
`endif

    typedef struct packed {
        logic [3:0] p;
        logic [3:0] c;
        logic [6:0] cw;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp = '0;
    int   tests = 0;
    int   fails = 0;

    hamming_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .e         (e),
        .out_valid (out_valid),
        .p         (p),
        .c         (c),
        .cw        (cw)
`ifdef HAM_ERR_COUNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Bench-side encoder: data {pos7,pos6,pos5,pos3}
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Drive one valid word, push its expectation, then pop and compare after the edge
    task automatic send(input string tag, input logic [6:0] word,
                        input logic [3:0] ep, input logic [3:0] ec, input logic [6:0] ecw);
        exp_t x;
        exp_q.push_back('{p: ep, c: ec, cw: ecw});
        rst      = 1'b0;
        in_valid = 1'b1;
        e        = word;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 16'd0, 16'd1);
        end else begin
            x = exp_q.pop_front();
            check({tag, "_valid"}, 16'(out_valid), 16'd1);
            check({tag, "_p"},     16'(p),  16'(x.p));
            check({tag, "_c"},     16'(c),  16'(x.c));
            check({tag, "_cw"},    16'(cw), 16'(x.cw));
            last_exp = x;
            $display("[TB] %s e=%b p=%b c=%b cw=%b", tag, word, p, c, cw);
        end
    endtask

    // Idle cycle: out_valid drops and registered outputs hold
    task automatic idle(input string tag);
        rst      = 1'b0;
        in_valid = 1'b0;
        e        = 7'($urandom);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_p"},     16'(p),  16'(last_exp.p));
        check({tag, "_c"},     16'(c),  16'(last_exp.c));
        check({tag, "_cw"},    16'(cw), 16'(last_exp.cw));
        $display("[TB] %s idle e=%b p=%b c=%b cw=%b", tag, e, p, c, cw);
    endtask

    // Reset with a valid word present: the word is dropped, everything clears
    task automatic do_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b1;
        e        = 7'b1110110;
        @(posedge clk);
        #1;
        exp_q.delete();
        last_exp = '0;
        check({tag, "_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_p"},     16'(p),  16'd0);
        check({tag, "_c"},     16'(c),  16'd0);
        check({tag, "_cw"},    16'(cw), 16'd0);
`ifdef HAM_ERR_COUNT_EN
        check({tag, "_cnt"},   err_cnt, 16'd0);
`endif
        $display("[TB] %s reset", tag);
    endtask

    initial begin
        logic [6:0] word;
        logic [6:0] good;
        logic [2:0] pos;

        do_reset("rst0");

        send("pos5err", 7'b1110110, 4'b1101, 4'b1101, 7'b1100110);
        send("clean",   7'b1100110, 4'b0000, 4'b1101, 7'b1100110);
        send("pos3only",7'b0000111, 4'b0000, 4'b0001, 7'b0000111);

        idle("gap0");
        idle("gap1");

        // Full sweep, back-to-back
        for (int d = 0; d < 16; d++) begin
            for (int k = 0; k < 8; k++) begin
                good = encode(4'(d));
                pos  = 3'(k);
                word = good ^ ((k == 0) ? 7'd0 : (7'd1 << (k - 1)));
                send($sformatf("sw_d%0d_k%0d", d, k), word, {k != 0, pos}, 4'(d), good);
            end
        end

        idle("gap2");
        send("after_gap", encode(4'hA) ^ 7'b0000010, 4'b1010, 4'hA, encode(4'hA));
        idle("gap3");

        // Reset in the middle of a stream
        send("pre_rst", encode(4'h5), 4'b0000, 4'h5, encode(4'h5));
        do_reset("rst_mid");
        idle("post_rst");

`ifdef HAM_ERR_COUNT_EN
        send("cnt_e1", encode(4'h1) ^ 7'b0000001, 4'b1001, 4'h1, encode(4'h1));
        send("cnt_c1", encode(4'h2),              4'b0000, 4'h2, encode(4'h2));
        send("cnt_e2", encode(4'h3) ^ 7'b1000000, 4'b1111, 4'h3, encode(4'h3));
        idle("cnt_gap");
        send("cnt_c2", encode(4'h4),              4'b0000, 4'h4, encode(4'h4));
        send("cnt_e3", encode(4'h6) ^ 7'b0001000, 4'b1100, 4'h6, encode(4'h6));
        check("err_cnt3", err_cnt, 16'd3);
        $display("[TB] err_cnt=%0d", err_cnt);

        // Push the counter past its ceiling with erroneous words
        rst      = 1'b0;
        in_valid = 1'b1;
        e        = encode(4'h9) ^ 7'b0010000;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        check("err_cnt_sat", err_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        check("err_cnt_sat_hold", err_cnt, 16'hFFFF);
        $display("[TB] saturated err_cnt=%h", err_cnt);
        do_reset("rst_cnt");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
